// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-code, state and strobe-bundle definitions for the control unit.
package control_unit_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ALU_W    = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [ALU_W-1:0]    alu_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;  // first R-type
  localparam opcode_t OP_OR   = 5'b01011;  // last R-type
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_JAL  = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam alu_t ALU_ADD = 5'b00011;
  localparam alu_t ALU_AND = 5'b01010;
  localparam alu_t ALU_OR  = 5'b01011;

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6, EX7, HALT
  } state_t;

  // One bit per strobe, plus the ALU operation code.
  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic mdr_out;
    logic c_out;
    logic r_out;
    logic ba_out;
    logic zmux_out;
    logic port_in_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic zlo_in;
    logic r_in;
    logic r15_in;
    logic con_in;
    logic inc_pc;
    logic read;
    logic write;
    logic ram_enable;
    logic gra;
    logic grb;
    logic grc;
    logic zmux_enable;
    logic zselect;
    logic out_port_enable;
    alu_t alu_control;
  } ctrl_t;

  // Final execute step of each instruction; the FSM returns to FETCH0 after it.
  function automatic state_t last_step(input opcode_t op);
    if (op == OP_LD || op == OP_ST)
      last_step = EX7;
    else if (op == OP_BR)
      last_step = EX6;
    else if (op == OP_LDI || op inside {[OP_ADD:OP_OR], [OP_ADDI:OP_ORI]})
      last_step = EX5;
    else if (op == OP_NEG || op == OP_NOT || op == OP_JAL)
      last_step = EX4;
    else
      last_step = EX3;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/condition in, strobes out.
interface control_unit_if;
  import control_unit_pkg::*;

  logic [INSTR_W-1:0] IR;
  logic               CON_FF;

  logic PCout, ZLOout, ZHIout, MDRout, Cout, Rout, BAout, ZMuxOut, PortInout;
  logic MARin, PCin, MDRin, IRin, Yin, ZLOin, Rin, R15in, conin;
  logic IncPC, read, write, RAMenable, Gra, Grb, Grc, ZMuxEnable, ZSelect, OutPortenable;
  logic [ALU_W-1:0] aluControl;
  logic run;

  modport master (
    input  IR, CON_FF,
    output PCout, ZLOout, ZHIout, MDRout, Cout, Rout, BAout, ZMuxOut, PortInout,
    output MARin, PCin, MDRin, IRin, Yin, ZLOin, Rin, R15in, conin,
    output IncPC, read, write, RAMenable, Gra, Grb, Grc, ZMuxEnable, ZSelect, OutPortenable,
    output aluControl, run
  );

  modport slave (
    output IR, CON_FF,
    input  PCout, ZLOout, ZHIout, MDRout, Cout, Rout, BAout, ZMuxOut, PortInout,
    input  MARin, PCin, MDRin, IRin, Yin, ZLOin, Rin, R15in, conin,
    input  IncPC, read, write, RAMenable, Gra, Grb, Grc, ZMuxEnable, ZSelect, OutPortenable,
    input  aluControl, run
  );
endinterface

// File: rtl/control_unit.sv
// Moore control FSM: fetch, then opcode-specific execute steps, with a halt sink.
module control_unit
  import control_unit_pkg::*;
(
  input logic             clock,
  input logic             clear,
  control_unit_if.master  bus
);

  state_t  state, state_nx;
  logic    active;   // low from reset until the first edge, holding FETCH0 strobes off
  opcode_t op;
  ctrl_t   c;
  logic    is_addr, is_mem, is_rtype, is_imm, is_unary;

  assign op       = bus.IR[INSTR_W-1 -: OPCODE_W];
  assign is_mem   = (op == OP_LD) || (op == OP_ST);
  assign is_addr  = is_mem || (op == OP_LDI);
  assign is_rtype = op inside {[OP_ADD:OP_OR]};
  assign is_imm   = op inside {[OP_ADDI:OP_ORI]};
  assign is_unary = (op == OP_NEG) || (op == OP_NOT);

  // State register; the first edge after reset only arms the outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= FETCH0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active) state <= state_nx;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH0: state_nx = FETCH1;
      FETCH1: state_nx = FETCH2;
      FETCH2: state_nx = EX3;
      EX3:    state_nx = (op == OP_HALT) ? HALT :
                         (last_step(op) == EX3) ? FETCH0 : EX4;
      EX4:    state_nx = (last_step(op) == EX4) ? FETCH0 : EX5;
      EX5:    state_nx = (last_step(op) == EX5) ? FETCH0 : EX6;
      EX6:    state_nx = (last_step(op) == EX6) ? FETCH0 : EX7;
      EX7:    state_nx = FETCH0;
      HALT:   state_nx = HALT;
      default: state_nx = FETCH0;
    endcase
  end

  // Output decoder keyed on (state, opcode); everything idle while in reset.
  always_comb begin
    c = '0;
    if (active) begin
      case (state)
        FETCH0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
        FETCH1: begin c.read = 1'b1; c.ram_enable = 1'b1; c.mdr_in = 1'b1; end
        FETCH2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
        EX3: begin
          if (is_addr) begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end else if (is_rtype || is_imm) begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end else if (is_unary) begin
            c.grb = 1'b1; c.r_out = 1'b1; c.alu_control = op; c.zlo_in = 1'b1;
          end else if (op == OP_BR) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
          end else if (op == OP_JR) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
          end else if (op == OP_JAL) begin
            c.pc_out = 1'b1; c.r15_in = 1'b1;
          end else if (op == OP_IN) begin
            c.port_in_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end else if (op == OP_OUT) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.out_port_enable = 1'b1;
          end
        end
        EX4: begin
          if (is_addr) begin
            c.c_out = 1'b1; c.alu_control = ALU_ADD; c.zlo_in = 1'b1;
          end else if (is_rtype) begin
            c.grc = 1'b1; c.r_out = 1'b1; c.alu_control = op; c.zlo_in = 1'b1;
          end else if (is_imm) begin
            c.c_out  = 1'b1; c.zlo_in = 1'b1;
            c.alu_control = (op == OP_ADDI) ? ALU_ADD : (op == OP_ANDI) ? ALU_AND : ALU_OR;
          end else if (is_unary) begin
            c.zmux_enable = 1'b1; c.zmux_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end else if (op == OP_BR) begin
            c.pc_out = 1'b1; c.y_in = 1'b1;
          end else if (op == OP_JAL) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
          end
        end
        EX5: begin
          if (is_mem) begin
            c.zmux_enable = 1'b1; c.zmux_out = 1'b1; c.mar_in = 1'b1;
          end else if (op == OP_LDI || is_rtype || is_imm) begin
            c.zmux_enable = 1'b1; c.zmux_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end else if (op == OP_BR) begin
            c.c_out = 1'b1; c.alu_control = ALU_ADD; c.zlo_in = 1'b1;
          end
        end
        EX6: begin
          if (op == OP_ST) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
          end else if (op == OP_LD) begin
            c.read = 1'b1; c.ram_enable = 1'b1; c.mdr_in = 1'b1;
          end else if (op == OP_BR) begin
            c.zmux_enable = 1'b1; c.zmux_out = 1'b1; c.pc_in = bus.CON_FF;
          end
        end
        EX7: begin
          if (op == OP_ST) begin
            c.write = 1'b1; c.ram_enable = 1'b1;
          end else if (op == OP_LD) begin
            c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
        end
        default: c = '0;
      endcase
    end
  end

  // Drive the bundle from the decoded strobes.
  assign bus.PCout         = c.pc_out;
  assign bus.ZLOout        = c.zlo_out;
  assign bus.ZHIout        = c.zhi_out;
  assign bus.MDRout        = c.mdr_out;
  assign bus.Cout          = c.c_out;
  assign bus.Rout          = c.r_out;
  assign bus.BAout         = c.ba_out;
  assign bus.ZMuxOut       = c.zmux_out;
  assign bus.PortInout     = c.port_in_out;
  assign bus.MARin         = c.mar_in;
  assign bus.PCin          = c.pc_in;
  assign bus.MDRin         = c.mdr_in;
  assign bus.IRin          = c.ir_in;
  assign bus.Yin           = c.y_in;
  assign bus.ZLOin         = c.zlo_in;
  assign bus.Rin           = c.r_in;
  assign bus.R15in         = c.r15_in;
  assign bus.conin         = c.con_in;
  assign bus.IncPC         = c.inc_pc;
  assign bus.read          = c.read;
  assign bus.write         = c.write;
  assign bus.RAMenable     = c.ram_enable;
  assign bus.Gra           = c.gra;
  assign bus.Grb           = c.grb;
  assign bus.Grc           = c.grc;
  assign bus.ZMuxEnable    = c.zmux_enable;
  assign bus.ZSelect       = c.zselect;
  assign bus.OutPortenable = c.out_port_enable;
  assign bus.aluControl    = c.alu_control;
  assign bus.run           = active && (state != HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-state strobe vectors checked against hand-written masks.
module tb_control_unit;
  import control_unit_pkg::*;

  logic clock;
  logic clear;
  control_unit_if bus();

  control_unit dut (.clock(clock), .clear(clear), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Strobe masks; low five bits carry aluControl.
  localparam logic [32:0] PCOUT   = 33'd1 << 32;
  localparam logic [32:0] ZLOOUT  = 33'd1 << 31;
  localparam logic [32:0] ZHIOUT  = 33'd1 << 30;
  localparam logic [32:0] MDROUT  = 33'd1 << 29;
  localparam logic [32:0] COUT    = 33'd1 << 28;
  localparam logic [32:0] ROUT    = 33'd1 << 27;
  localparam logic [32:0] BAOUT   = 33'd1 << 26;
  localparam logic [32:0] ZMUXOUT = 33'd1 << 25;
  localparam logic [32:0] PORTIN  = 33'd1 << 24;
  localparam logic [32:0] MARIN   = 33'd1 << 23;
  localparam logic [32:0] PCIN    = 33'd1 << 22;
  localparam logic [32:0] MDRIN   = 33'd1 << 21;
  localparam logic [32:0] IRIN    = 33'd1 << 20;
  localparam logic [32:0] YIN     = 33'd1 << 19;
  localparam logic [32:0] ZLOIN   = 33'd1 << 18;
  localparam logic [32:0] RIN     = 33'd1 << 17;
  localparam logic [32:0] R15IN   = 33'd1 << 16;
  localparam logic [32:0] CONIN   = 33'd1 << 15;
  localparam logic [32:0] INCPC   = 33'd1 << 14;
  localparam logic [32:0] READ    = 33'd1 << 13;
  localparam logic [32:0] WRITE   = 33'd1 << 12;
  localparam logic [32:0] RAMEN   = 33'd1 << 11;
  localparam logic [32:0] GRA     = 33'd1 << 10;
  localparam logic [32:0] GRB     = 33'd1 << 9;
  localparam logic [32:0] GRC     = 33'd1 << 8;
  localparam logic [32:0] ZMUXEN  = 33'd1 << 7;
  localparam logic [32:0] ZSEL    = 33'd1 << 6;
  localparam logic [32:0] OUTPEN  = 33'd1 << 5;
  localparam logic [32:0] ZBUS    = ZMUXEN | ZMUXOUT;
  localparam logic [32:0] F0      = PCOUT | MARIN | INCPC;
  localparam logic [32:0] F1      = READ | RAMEN | MDRIN;
  localparam logic [32:0] F2      = MDROUT | IRIN;

  logic [32:0] obs;
  assign obs = {bus.PCout, bus.ZLOout, bus.ZHIout, bus.MDRout, bus.Cout, bus.Rout,
                bus.BAout, bus.ZMuxOut, bus.PortInout,
                bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.ZLOin, bus.Rin,
                bus.R15in, bus.conin,
                bus.IncPC, bus.read, bus.write, bus.RAMenable, bus.Gra, bus.Grb, bus.Grc,
                bus.ZMuxEnable, bus.ZSelect, bus.OutPortenable,
                bus.aluControl};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [32:0] exp_v, input logic exp_run);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: outputs=%h expected=%h", tag, obs, exp_v);
    end
    tests++;
    assert (bus.run === exp_run) else begin
      fails++;
      $error("FAIL %s_run: run=%b expected=%b", tag, bus.run, exp_run);
    end
  endtask

  // Advance one clock and sample mid-cycle.
  task automatic step_check(input string tag, input logic [32:0] exp_v, input logic exp_run);
    @(posedge clock);
    #1;
    check(tag, exp_v, exp_run);
  endtask

  task automatic fetch12();
    step_check("fetch1", F1, 1'b1);
    step_check("fetch2", F2, 1'b1);
  endtask

  // Pulse clear low between edges (we are 1 time unit after a rising edge).
  task automatic clear_pulse(input string tag);
    #2 clear = 1'b0;
    #1 check(tag, '0, 1'b0);
    #1 clear = 1'b1;
  endtask

  initial begin
    clear      = 1'b0;
    bus.IR     = '0;
    bus.CON_FF = 1'b0;

    // Reset state
    #12 check("reset", '0, 1'b0);
    clear  = 1'b1;
    bus.IR = {OP_ST, 4'd1, 4'd2, 19'h00010};

    // st R1,0x10(R2)
    step_check("st_f0", F0, 1'b1);
    fetch12();
    step_check("st_ex3", GRB | BAOUT | YIN, 1'b1);
    step_check("st_ex4", COUT | ZLOIN | 33'(ALU_ADD), 1'b1);
    step_check("st_ex5", ZBUS | MARIN, 1'b1);
    step_check("st_ex6", GRA | ROUT | MDRIN, 1'b1);
    step_check("st_ex7", WRITE | RAMEN, 1'b1);
    step_check("st_done", F0, 1'b1);

    // add R3,R4,R5 counted from a fresh reset: FETCH0 again at the 7th edge
    clear_pulse("add_clear");
    bus.IR = {OP_ADD, 4'd3, 4'd4, 4'd5, 15'd0};
    step_check("add_e1_f0", F0, 1'b1);
    fetch12();
    step_check("add_ex3", GRB | ROUT | YIN, 1'b1);
    step_check("add_ex4", GRC | ROUT | ZLOIN | 33'd3, 1'b1);
    step_check("add_ex5", ZBUS | GRA | RIN, 1'b1);
    step_check("add_e7_f0", F0, 1'b1);

    // br taken
    bus.IR     = {OP_BR, 4'd2, 4'b0011, 19'h00004};
    bus.CON_FF = 1'b1;
    fetch12();
    step_check("br1_ex3", GRA | ROUT | CONIN, 1'b1);
    step_check("br1_ex4", PCOUT | YIN, 1'b1);
    step_check("br1_ex5", COUT | ZLOIN | 33'(ALU_ADD), 1'b1);
    step_check("br1_ex6", ZBUS | PCIN, 1'b1);
    step_check("br1_done", F0, 1'b1);

    // br not taken
    bus.CON_FF = 1'b0;
    fetch12();
    step_check("br0_ex3", GRA | ROUT | CONIN, 1'b1);
    step_check("br0_ex4", PCOUT | YIN, 1'b1);
    step_check("br0_ex5", COUT | ZLOIN | 33'(ALU_ADD), 1'b1);
    step_check("br0_ex6", ZBUS, 1'b1);
    step_check("br0_done", F0, 1'b1);

    // andi: immediate operand, AND code
    bus.IR = {OP_ANDI, 4'd1, 4'd2, 19'h0000F};
    fetch12();
    step_check("andi_ex3", GRB | ROUT | YIN, 1'b1);
    step_check("andi_ex4", COUT | ZLOIN | 33'd10, 1'b1);
    step_check("andi_ex5", ZBUS | GRA | RIN, 1'b1);
    step_check("andi_done", F0, 1'b1);

    // not: two execute steps
    bus.IR = {OP_NOT, 4'd6, 4'd7, 19'd0};
    fetch12();
    step_check("not_ex3", GRB | ROUT | ZLOIN | 33'd18, 1'b1);
    step_check("not_ex4", ZBUS | GRA | RIN, 1'b1);
    step_check("not_done", F0, 1'b1);

    // jal
    bus.IR = {OP_JAL, 4'd9, 23'd0};
    fetch12();
    step_check("jal_ex3", PCOUT | R15IN, 1'b1);
    step_check("jal_ex4", GRA | ROUT | PCIN, 1'b1);
    step_check("jal_done", F0, 1'b1);

    // out
    bus.IR = {OP_OUT, 4'd4, 23'd0};
    fetch12();
    step_check("out_ex3", GRA | ROUT | OUTPEN, 1'b1);
    step_check("out_done", F0, 1'b1);

    // Unassigned opcode 11110: one empty execute step
    bus.IR = {5'b11110, 27'd0};
    fetch12();
    step_check("op1e_ex3", '0, 1'b1);
    step_check("op1e_done", F0, 1'b1);

    // ld interrupted by clear during EX5
    bus.IR = {OP_LD, 4'd1, 4'd2, 19'h00020};
    fetch12();
    step_check("ld_ex3", GRB | BAOUT | YIN, 1'b1);
    step_check("ld_ex4", COUT | ZLOIN | 33'(ALU_ADD), 1'b1);
    step_check("ld_ex5", ZBUS | MARIN, 1'b1);
    clear_pulse("ld_clear");
    step_check("ld_restart_f0", F0, 1'b1);
    step_check("ld_restart_f1", F1, 1'b1);
    step_check("ld_restart_f2", F2, 1'b1);

    // halt: sink until clear
    bus.IR = {OP_HALT, 27'd0};
    step_check("halt_ex3", '0, 1'b1);
    for (int i = 0; i < 5; i++) step_check("halt_hold", '0, 1'b0);
    clear_pulse("halt_clear");
    bus.IR = {5'b11010, 27'd0};
    step_check("halt_exit_f0", F0, 1'b1);
    step_check("halt_exit_f1", F1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IR, input, 32 bits: instruction register contents; opcode is IR[31:27].
REQ-004 SHALL have port CON_FF, input, 1 bit: branch-condition flag from the datapath.
REQ-005 SHALL have bus-source strobes PCout, ZLOout, ZHIout, MDRout, Cout, Rout, BAout, ZMuxOut, PortInout, each an output of 1 bit.
REQ-006 SHALL have register-load strobes MARin, PCin, MDRin, IRin, Yin, ZLOin, Rin, R15in, conin, each an output of 1 bit.
REQ-007 SHALL have control outputs IncPC, read, write, RAMenable, Gra, Grb, Grc, ZMuxEnable, ZSelect, OutPortenable, each 1 bit.
REQ-008 SHALL have port aluControl, output, 5 bits: ALU operation code.
REQ-009 SHALL have port run, output, 1 bit: 1 while executing, 0 in HALT.

Function
REQ-010 SHALL be a Moore FSM with states FETCH0, FETCH1, FETCH2, EX3..EX7 and HALT; each state lasts exactly one clock.
REQ-011 SHALL drive every output 0 (aluControl 00000) except the strobes listed for the current state.
REQ-012 "Zbus" SHALL denote ZMuxEnable=1, ZMuxOut=1, ZSelect=0.
REQ-013 Fetch SHALL be: FETCH0 PCout, MARin, IncPC; FETCH1 read, RAMenable, MDRin; FETCH2 MDRout, IRin; then EX3.
REQ-014 SHALL decode IR[31:27] in EX3 and all later states.
REQ-015 st (00010) SHALL be: EX3 Grb, BAout, Yin; EX4 Cout, aluControl=00011, ZLOin; EX5 Zbus, MARin; EX6 Gra, Rout, MDRin; EX7 write, RAMenable.
REQ-016 ld (00000) SHALL be: EX3-EX5 as st; EX6 read, RAMenable, MDRin; EX7 MDRout, Gra, Rin.
REQ-017 ldi (00001) SHALL be: EX3-EX4 as st; EX5 Zbus, Gra, Rin.
REQ-018 R-type (00011-01011) SHALL be: EX3 Grb, Rout, Yin; EX4 Grc, Rout, aluControl=opcode, ZLOin; EX5 Zbus, Gra, Rin.
REQ-019 addi/andi/ori (01100/01101/01110) SHALL be: as R-type, except EX4 uses Cout in place of Grc/Rout, with aluControl 00011/01010/01011 respectively.
REQ-020 neg/not (10001/10010) SHALL be: EX3 Grb, Rout, aluControl=opcode, ZLOin; EX4 Zbus, Gra, Rin.
REQ-021 br (10011) SHALL be: EX3 Gra, Rout, conin; EX4 PCout, Yin; EX5 Cout, aluControl=00011, ZLOin; EX6 Zbus plus PCin only if CON_FF=1.
REQ-022 jr (10100) SHALL be: EX3 Gra, Rout, PCin.
REQ-023 jal (10101) SHALL be: EX3 PCout, R15in; EX4 Gra, Rout, PCin.
REQ-024 in (10110) SHALL be: EX3 PortInout, Gra, Rin; out (10111) SHALL be: EX3 Gra, Rout, OutPortenable.
REQ-025 halt (11011) SHALL enter HALT from EX3; HALT SHALL be exited only by clear.
REQ-026 nop and every other opcode (mul, div, mfhi, mflo, 11100-11111) SHALL execute an empty EX3.
REQ-027 After the last listed step of any instruction, the FSM SHALL return to FETCH0.
REQ-028 CON_FF SHALL be sampled only in EX6 of br.

Reset
REQ-029 clear=0 SHALL asynchronously force FETCH0 with all outputs 0 and run=0, including mid-instruction and in HALT.
REQ-030 The first rising edge after clear rises SHALL leave FETCH0 in effect, asserting its strobes for that full cycle; run=1 in every non-HALT state.

Structure
REQ-031 Opcode constants, ALU codes and the state encoding SHALL reside in a shared package, also used by DataPath and the benches.
REQ-032 The block SHALL be flat, with no sub-module; a single combinational output decoder is keyed on (state, opcode).

Verification
REQ-033 Bench SHALL cover: reset, then IR=st R1,0x10(R2) -> FETCH0-2 then EX3-EX7 strobes exactly per REQ-015; write=1 only in EX7.
REQ-034 Bench SHALL cover: IR=add (00011) -> EX4 aluControl=00011 with Grc=1; Rin=1 only in EX5; FETCH0 follows at the 7th edge.
REQ-035 Bench SHALL cover: br with CON_FF=1, then CON_FF=0 -> PCin=1 in EX6 only in the first case.
REQ-036 Bench SHALL cover: IR=halt -> run=0 indefinitely; clear pulse low -> FETCH0, run=1.
REQ-037 Bench SHALL cover: clear asserted during EX5 of ld -> all outputs 0 immediately; fetch restarts after release.
REQ-038 Bench SHALL cover: IR opcode 11110 -> one empty EX3, then FETCH0.
